// File: rtl/csr_regfile.sv
// csr_regfile: machine-mode CSR register file for the RV64 pipeline.
// Serves the EX-stage CSR read and commits the CSR ALU result at WB.
// It also handles trap entry, mret, the cycle/instret counters and interrupt-pending.
// Ports:
//   clk, rst                          clock and synchronous active-high reset
//   csr_raddr -> csr_rdata,           combinational EX read; csr_illegal flags
//   csr_illegal                       an unimplemented address
//   csr_we, csr_waddr, csr_wdata      WB commit of the CSR ALU result
//   retire                            one instruction retired (minstret)
//   trap_valid, trap_pc,              trap entry; trap_target is the handler PC
//   trap_cause, trap_val,             for the present trap_cause
//   trap_target
//   mret_valid, mret_target           mret commit; mret_target is mepc
//   irq_timer, irq_ext, irq_pending   interrupt levels in, pending-and-enabled out
module csr_regfile #(
   parameter int unsigned XLEN         = 64,
   parameter logic [63:0] MTVEC_RESET  = 64'h0,
   parameter bit          HAS_COUNTERS = 1'b1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [11:0]     csr_raddr,
   output logic [XLEN-1:0] csr_rdata,
   output logic            csr_illegal,
   input  logic            csr_we,
   input  logic [11:0]     csr_waddr,
   input  logic [XLEN-1:0] csr_wdata,
   input  logic            retire,
   input  logic            trap_valid,
   input  logic [XLEN-1:0] trap_pc,
   input  logic [XLEN-1:0] trap_cause,
   input  logic [XLEN-1:0] trap_val,
   input  logic            mret_valid,
   input  logic            irq_timer,
   input  logic            irq_ext,
   output logic [XLEN-1:0] trap_target,
   output logic [XLEN-1:0] mret_target,
   output logic            irq_pending
);

   localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
   localparam logic [11:0] ADDR_MIE      = 12'h304;
   localparam logic [11:0] ADDR_MTVEC    = 12'h305;
   localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
   localparam logic [11:0] ADDR_MEPC     = 12'h341;
   localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
   localparam logic [11:0] ADDR_MTVAL    = 12'h343;
   localparam logic [11:0] ADDR_MIP      = 12'h344;
   localparam logic [11:0] ADDR_MCYCLE   = 12'hB00;
   localparam logic [11:0] ADDR_MINSTRET = 12'hB02;
   localparam logic [11:0] ADDR_CYCLE    = 12'hC00;
   localparam logic [11:0] ADDR_INSTRET  = 12'hC02;

   localparam logic [XLEN-1:0] MIE_MASK = XLEN'(64'h880);

   // mstatus keeps only MIE and MPIE as state; MPP is hardwired to M-mode
   logic            mstatus_mie_q,  mstatus_mie_d;
   logic            mstatus_mpie_q, mstatus_mpie_d;
   logic [XLEN-1:0] mie_q,      mie_d;
   logic [XLEN-1:0] mtvec_q,    mtvec_d;
   logic [XLEN-1:0] mscratch_q, mscratch_d;
   logic [XLEN-1:0] mepc_q,     mepc_d;
   logic [XLEN-1:0] mcause_q,   mcause_d;
   logic [XLEN-1:0] mtval_q,    mtval_d;
   logic [XLEN-1:0] mcycle_q,   mcycle_d;
   logic [XLEN-1:0] minstret_q, minstret_d;

   logic [XLEN-1:0] mstatus_rd;
   logic [XLEN-1:0] mip_rd;
   logic [XLEN-1:0] tvec_base;
   logic            wr_en;

   assign mstatus_rd = {51'b0, 2'b11, 3'b0, mstatus_mpie_q, 3'b0, mstatus_mie_q, 3'b0};
   assign mip_rd     = {52'b0, irq_ext, 3'b0, irq_timer, 7'b0};
   assign wr_en      = csr_we && (csr_waddr[11:10] != 2'b11);

   // EX read mux
   always_comb begin
      csr_rdata   = '0;
      csr_illegal = 1'b0;
      case (csr_raddr)
         ADDR_MSTATUS:             csr_rdata = mstatus_rd;
         ADDR_MIE:                 csr_rdata = mie_q;
         ADDR_MTVEC:               csr_rdata = mtvec_q;
         ADDR_MSCRATCH:            csr_rdata = mscratch_q;
         ADDR_MEPC:                csr_rdata = mepc_q;
         ADDR_MCAUSE:              csr_rdata = mcause_q;
         ADDR_MTVAL:               csr_rdata = mtval_q;
         ADDR_MIP:                 csr_rdata = mip_rd;
         ADDR_MCYCLE, ADDR_CYCLE:  csr_rdata = mcycle_q;
         ADDR_MINSTRET,
         ADDR_INSTRET:             csr_rdata = minstret_q;
         default:                  csr_illegal = 1'b1;
      endcase
   end

   // Handler PC: vectored mode only offsets interrupts
   assign tvec_base   = {mtvec_q[XLEN-1:2], 2'b00};
   assign trap_target = (mtvec_q[0] && trap_cause[XLEN-1])
                        ? tvec_base + {56'b0, trap_cause[5:0], 2'b00}
                        : tvec_base;
   assign mret_target = mepc_q;
   assign irq_pending = mstatus_mie_q && ((mie_q & mip_rd) != '0);

   // Next state; later assignments take priority, giving trap > mret > csr_we
   // on the CSRs they share while other CSR writes still commit.
   always_comb begin
      mstatus_mie_d  = mstatus_mie_q;
      mstatus_mpie_d = mstatus_mpie_q;
      mie_d          = mie_q;
      mtvec_d        = mtvec_q;
      mscratch_d     = mscratch_q;
      mepc_d         = mepc_q;
      mcause_d       = mcause_q;
      mtval_d        = mtval_q;
      mcycle_d       = HAS_COUNTERS ? mcycle_q + XLEN'(1) : '0;
      minstret_d     = (HAS_COUNTERS && retire) ? minstret_q + XLEN'(1) : minstret_q;

      if (wr_en) begin
         case (csr_waddr)
            ADDR_MSTATUS: begin
               mstatus_mie_d  = csr_wdata[3];
               mstatus_mpie_d = csr_wdata[7];
            end
            ADDR_MIE:      mie_d      = csr_wdata & MIE_MASK;
            ADDR_MTVEC:    mtvec_d    = {csr_wdata[XLEN-1:2], 1'b0, csr_wdata[0]};
            ADDR_MSCRATCH: mscratch_d = csr_wdata;
            ADDR_MEPC:     mepc_d     = {csr_wdata[XLEN-1:2], 2'b00};
            ADDR_MCAUSE:   mcause_d   = csr_wdata;
            ADDR_MTVAL:    mtval_d    = csr_wdata;
            ADDR_MCYCLE:   if (HAS_COUNTERS) mcycle_d   = csr_wdata;
            ADDR_MINSTRET: if (HAS_COUNTERS) minstret_d = csr_wdata;
            default: ;
         endcase
      end

      if (mret_valid) begin
         mstatus_mie_d  = mstatus_mpie_q;
         mstatus_mpie_d = 1'b1;
      end

      if (trap_valid) begin
         mepc_d         = {trap_pc[XLEN-1:2], 2'b00};
         mcause_d       = trap_cause;
         mtval_d        = trap_val;
         mstatus_mpie_d = mstatus_mie_q;
         mstatus_mie_d  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mstatus_mie_q  <= 1'b0;
         mstatus_mpie_q <= 1'b0;
         mie_q          <= '0;
         mtvec_q        <= XLEN'(MTVEC_RESET);
         mscratch_q     <= '0;
         mepc_q         <= '0;
         mcause_q       <= '0;
         mtval_q        <= '0;
         mcycle_q       <= '0;
         minstret_q     <= '0;
      end else begin
         mstatus_mie_q  <= mstatus_mie_d;
         mstatus_mpie_q <= mstatus_mpie_d;
         mie_q          <= mie_d;
         mtvec_q        <= mtvec_d;
         mscratch_q     <= mscratch_d;
         mepc_q         <= mepc_d;
         mcause_q       <= mcause_d;
         mtval_q        <= mtval_d;
         mcycle_q       <= mcycle_d;
         minstret_q     <= minstret_d;
      end
   end

endmodule

// File: tb/tb_csr_regfile.sv
// tb_csr_regfile: testbench for csr_regfile.
// It runs directed scenarios and then random stimulus.
// Every output is compared with a behavioural model of the CSR rules.
module tb_csr_regfile;

   localparam logic [63:0] MTVEC_RST = 64'h0000_0000_0000_1000;

   logic        clk = 1'b0;
   logic        rst;
   logic [11:0] csr_raddr;
   logic [63:0] csr_rdata;
   logic        csr_illegal;
   logic        csr_we;
   logic [11:0] csr_waddr;
   logic [63:0] csr_wdata;
   logic        retire;
   logic        trap_valid;
   logic [63:0] trap_pc;
   logic [63:0] trap_cause;
   logic [63:0] trap_val;
   logic        mret_valid;
   logic        irq_timer;
   logic        irq_ext;
   logic [63:0] trap_target;
   logic [63:0] mret_target;
   logic        irq_pending;

   always #50 clk = ~clk;

   csr_regfile #(
      .XLEN        (64),
      .MTVEC_RESET (MTVEC_RST),
      .HAS_COUNTERS(1'b1)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .csr_raddr  (csr_raddr),
      .csr_rdata  (csr_rdata),
      .csr_illegal(csr_illegal),
      .csr_we     (csr_we),
      .csr_waddr  (csr_waddr),
      .csr_wdata  (csr_wdata),
      .retire     (retire),
      .trap_valid (trap_valid),
      .trap_pc    (trap_pc),
      .trap_cause (trap_cause),
      .trap_val   (trap_val),
      .mret_valid (mret_valid),
      .irq_timer  (irq_timer),
      .irq_ext    (irq_ext),
      .trap_target(trap_target),
      .mret_target(mret_target),
      .irq_pending(irq_pending)
   );

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   logic [11:0] impl_addrs [12] = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
                                   12'h343, 12'h344, 12'hB00, 12'hB02, 12'hC00, 12'hC02};

   // Reference model state: full architectural CSR values
   logic [63:0] m_mstatus, m_mie, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval;
   logic [63:0] m_mcycle, m_minstret;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   function automatic logic [63:0] model_mip();
      return (irq_timer ? 64'h80 : 64'h0) | (irq_ext ? 64'h800 : 64'h0);
   endfunction

   // {illegal, value} for a read of address a
   function automatic logic [64:0] model_read(input logic [11:0] a);
      case (a)
         12'h300: return {1'b0, m_mstatus};
         12'h304: return {1'b0, m_mie};
         12'h305: return {1'b0, m_mtvec};
         12'h340: return {1'b0, m_mscratch};
         12'h341: return {1'b0, m_mepc};
         12'h342: return {1'b0, m_mcause};
         12'h343: return {1'b0, m_mtval};
         12'h344: return {1'b0, model_mip()};
         12'hB00, 12'hC00: return {1'b0, m_mcycle};
         12'hB02, 12'hC02: return {1'b0, m_minstret};
         default: return {1'b1, 64'h0};
      endcase
   endfunction

   function automatic logic [63:0] model_trap_target();
      logic [63:0] base;
      base = m_mtvec - (m_mtvec % 4);
      if ((m_mtvec % 2 == 1) && trap_cause[63]) return base + 4 * (trap_cause % 64);
      return base;
   endfunction

   // Advance the model by one clock edge using the inputs held this cycle
   task automatic model_step();
      bit wr, blocked;
      if (rst) begin
         m_mstatus = 64'h1800; m_mtvec = MTVEC_RST;
         m_mie = 0; m_mscratch = 0; m_mepc = 0; m_mcause = 0; m_mtval = 0;
         m_mcycle = 0; m_minstret = 0;
         return;
      end
      wr      = csr_we && (csr_waddr < 12'hC00);
      blocked = (trap_valid && (csr_waddr inside {12'h300, 12'h341, 12'h342, 12'h343}))
             || (mret_valid && csr_waddr == 12'h300);
      m_mcycle = m_mcycle + 1;
      if (retire) m_minstret = m_minstret + 1;
      if (wr && !blocked) begin
         case (csr_waddr)
            12'h300: m_mstatus  = 64'h1800 | (csr_wdata & 64'h88);
            12'h304: m_mie      = csr_wdata & 64'h880;
            12'h305: m_mtvec    = csr_wdata & ~64'h2;
            12'h340: m_mscratch = csr_wdata;
            12'h341: m_mepc     = csr_wdata & ~64'h3;
            12'h342: m_mcause   = csr_wdata;
            12'h343: m_mtval    = csr_wdata;
            12'hB00: m_mcycle   = csr_wdata;
            12'hB02: m_minstret = csr_wdata;
            default: ;
         endcase
      end
      if (trap_valid) begin
         m_mepc    = trap_pc & ~64'h3;
         m_mcause  = trap_cause;
         m_mtval   = trap_val;
         m_mstatus = 64'h1800 | (m_mstatus[3] ? 64'h80 : 64'h0);
      end else if (mret_valid) begin
         m_mstatus = 64'h1880 | (m_mstatus[7] ? 64'h8 : 64'h0);
      end
   endtask

   task automatic clock();
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   task automatic idle();
      csr_we = 1'b0; trap_valid = 1'b0; mret_valid = 1'b0; retire = 1'b0;
   endtask

   task automatic write(input logic [11:0] a, input logic [63:0] d);
      csr_we = 1'b1; csr_waddr = a; csr_wdata = d;
   endtask

   task automatic rd(input string tag, input logic [11:0] a, input logic [63:0] exp);
      csr_raddr = a;
      #1;
      check_eq(tag, csr_rdata, exp);
   endtask

   // Compare every read address and every combinational output against the model
   task automatic check_all(input string tag);
      logic [64:0] e;
      for (int i = 0; i < 13; i++) begin
         csr_raddr = (i < 12) ? impl_addrs[i] : 12'($urandom);
         #1;
         e = model_read(csr_raddr);
         check_eq($sformatf("%s rdata@%h", tag, csr_raddr), csr_rdata, e[63:0]);
         check_eq($sformatf("%s illegal@%h", tag, csr_raddr), 64'(csr_illegal), 64'(e[64]));
      end
      check_eq({tag, " trap_target"}, trap_target, model_trap_target());
      check_eq({tag, " mret_target"}, mret_target, m_mepc);
      check_eq({tag, " irq_pending"}, 64'(irq_pending),
               64'(m_mstatus[3] && ((m_mie & model_mip()) != 0)));
   endtask

   initial begin
      rst = 1'b1; csr_raddr = '0; csr_waddr = '0; csr_wdata = '0;
      trap_pc = '0; trap_cause = '0; trap_val = '0; irq_timer = 1'b0; irq_ext = 1'b0;
      idle();
      clock();
      clock();
      rst = 1'b0;

      // Reset state
      rd("rst mstatus", 12'h300, 64'h1800);
      rd("rst mtvec", 12'h305, MTVEC_RST);
      rd("rst mepc", 12'h341, 64'h0);
      rd("rst mcycle", 12'hB00, 64'h0);
      rd("rst unimpl", 12'h7C0, 64'h0);
      check_eq("rst illegal", 64'(csr_illegal), 64'h1);
      check_eq("rst trap_target", trap_target, MTVEC_RST);
      check_eq("rst mret_target", mret_target, 64'h0);
      check_eq("rst irq_pending", 64'(irq_pending), 64'h0);
      check_all("reset");

      // mtvec WARL and no same-cycle bypass
      write(12'h305, 64'h8000_0003);
      rd("mtvec same cycle", 12'h305, MTVEC_RST);
      clock(); idle();
      rd("mtvec next cycle", 12'h305, 64'h8000_0001);

      // mstatus WARL
      write(12'h300, '1);
      clock(); idle();
      rd("mstatus all ones", 12'h300, 64'h1888);

      // Trap entry then mret
      trap_valid = 1'b1; trap_pc = 64'h8000_0106; trap_cause = 64'h2; trap_val = 64'hDEAD;
      clock(); idle();
      rd("trap mepc", 12'h341, 64'h8000_0104);
      rd("trap mcause", 12'h342, 64'h2);
      rd("trap mtval", 12'h343, 64'hDEAD);
      rd("trap mstatus", 12'h300, 64'h1880);
      mret_valid = 1'b1;
      #1;
      check_eq("mret_target", mret_target, 64'h8000_0104);
      clock(); idle();
      rd("mret mstatus", 12'h300, 64'h1888);
      check_all("trap_mret");

      // Vectored trap target
      write(12'h305, 64'h101);
      clock(); idle();
      trap_cause = 64'h8000_0000_0000_0007;
      #1;
      check_eq("vectored irq target", trap_target, 64'h11C);
      trap_cause = 64'h2;
      #1;
      check_eq("vectored exc target", trap_target, 64'h100);

      // Trap beats a same-cycle mepc write
      trap_valid = 1'b1; trap_pc = 64'h200; trap_val = 64'h0;
      write(12'h341, 64'h40);
      clock(); idle();
      rd("trap vs we mepc", 12'h341, 64'h200);

      // Counter write beats increment, and wraps
      write(12'hB00, 64'h5);
      clock(); idle();
      rd("mcycle written", 12'hB00, 64'h5);
      clock();
      rd("mcycle +1", 12'hB00, 64'h6);
      write(12'hB02, '1);
      clock(); idle();
      retire = 1'b1;
      rd("minstret max", 12'hB02, '1);
      clock(); idle();
      rd("minstret wrap", 12'hB02, 64'h0);
      check_all("counters");

      // Interrupt pending
      write(12'h300, 64'h8);
      clock();
      write(12'h304, '1);
      clock(); idle();
      rd("mie mask", 12'h304, 64'h880);
      irq_timer = 1'b1;
      #1;
      check_eq("irq_pending timer", 64'(irq_pending), 64'h1);
      irq_timer = 1'b0;
      #1;
      check_eq("irq_pending drop", 64'(irq_pending), 64'h0);
      write(12'h344, '1);
      irq_ext = 1'b1;
      clock(); idle();
      rd("mip read-only", 12'h344, 64'h800);
      check_eq("irq_pending ext", 64'(irq_pending), 64'h1);
      check_all("irq");

      // Random stimulus against the model
      for (int n = 0; n < 400; n++) begin
         rst        = ($urandom_range(0, 63) == 0);
         csr_we     = $urandom_range(0, 1);
         csr_waddr  = ($urandom_range(0, 3) != 0) ? impl_addrs[$urandom_range(0, 11)]
                                                  : 12'($urandom);
         csr_wdata  = {$urandom, $urandom};
         retire     = $urandom_range(0, 1);
         trap_valid = ($urandom_range(0, 7) == 0);
         mret_valid = ($urandom_range(0, 7) == 0);
         trap_pc    = {$urandom, $urandom};
         trap_cause = {$urandom_range(0, 1) == 1, 57'($urandom), 6'($urandom)};
         trap_val   = {$urandom, $urandom};
         irq_timer  = $urandom_range(0, 1);
         irq_ext    = $urandom_range(0, 1);
         check_all("rnd");
         clock();
      end
      rst = 1'b0;
      idle();
      check_all("final");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
